// File: rtl/fb_rect_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fb_rect_fill_pkg
// Brief   : Shared types and sizes for the rectangle-fill engine.
// Revision: 1.0 - initial release
// ============================================================================
package fb_rect_fill_pkg;

  localparam int H_PIXELS_DEF = 160;
  localparam int V_PIXELS_DEF = 120;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int ADDR_W       = X_W + Y_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_FILL   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fb_raster_scan.sv
`default_nettype none
// ============================================================================
// Module  : fb_raster_scan
// Brief   : x/y raster walker over an inclusive rectangle, row-major order.
// Revision: 1.0 - initial release
// ============================================================================
module fb_raster_scan
  import fb_rect_fill_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic           i_en,
  input  logic [X_W-1:0] i_xl,
  input  logic [X_W-1:0] i_xr,
  input  logic [Y_W-1:0] i_yt,
  input  logic [Y_W-1:0] i_yb,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [X_W-1:0] r_xl;
  logic [X_W-1:0] r_xr;
  logic [Y_W-1:0] r_yb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_xl <= '0;
      r_xr <= '0;
      r_yb <= '0;
    end else if (i_load) begin
      r_x  <= i_xl;
      r_y  <= i_yt;
      r_xl <= i_xl;
      r_xr <= i_xr;
      r_yb <= i_yb;
    end else if (i_en && !o_last) begin
      // Holding on the last pixel keeps y from stepping past the bottom edge.
      if (r_x == r_xr) begin
        r_x <= r_xl;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == r_xr) && (r_y == r_yb);

endmodule
`default_nettype wire

// File: rtl/fb_rect_fill.sv
`default_nettype none
// ============================================================================
// Module  : fb_rect_fill
// Brief   : Fills an axis-aligned rectangle in a 1-bpp framebuffer, 1 px/clk.
// Revision: 1.0 - initial release
// ============================================================================
module fb_rect_fill
  import fb_rect_fill_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_PIXELS = V_PIXELS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [X_W-1:0]    i_cmd_x0,
  input  logic [X_W-1:0]    i_cmd_x1,
  input  logic [Y_W-1:0]    i_cmd_y0,
  input  logic [Y_W-1:0]    i_cmd_y1,
  input  logic              i_cmd_colour,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic              o_fb_data,
  output logic              o_fb_we,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [X_W-1:0] c_X_MAX = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0] c_Y_MAX = Y_W'(V_PIXELS - 1);

  state_t         r_state;
  state_t         w_next;
  logic [X_W-1:0] r_x0, r_x1;
  logic [Y_W-1:0] r_y0, r_y1;
  logic           r_colour;

  logic [X_W-1:0] w_xmin, w_xmax, w_xl, w_xr, w_x;
  logic [Y_W-1:0] w_ymin, w_ymax, w_yt, w_yb, w_y;
  logic           w_load, w_en, w_last, w_we, w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_x0     <= '0;
      r_x1     <= '0;
      r_y0     <= '0;
      r_y1     <= '0;
      r_colour <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_cmd_valid) begin
        r_x0     <= i_cmd_x0;
        r_x1     <= i_cmd_x1;
        r_y0     <= i_cmd_y0;
        r_y1     <= i_cmd_y1;
        r_colour <= i_cmd_colour;
      end
    end
  end

  // Sort the corners first, then clamp, so the ordering survives clamping.
  assign w_xmin = (r_x0 < r_x1) ? r_x0 : r_x1;
  assign w_xmax = (r_x0 < r_x1) ? r_x1 : r_x0;
  assign w_ymin = (r_y0 < r_y1) ? r_y0 : r_y1;
  assign w_ymax = (r_y0 < r_y1) ? r_y1 : r_y0;
  assign w_xl   = (w_xmin > c_X_MAX) ? c_X_MAX : w_xmin;
  assign w_xr   = (w_xmax > c_X_MAX) ? c_X_MAX : w_xmax;
  assign w_yt   = (w_ymin > c_Y_MAX) ? c_Y_MAX : w_ymin;
  assign w_yb   = (w_ymax > c_Y_MAX) ? c_Y_MAX : w_ymax;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_en   = 1'b0;
    w_we   = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) w_next = S_SETUP;
      end
      S_SETUP: begin
        if (i_abort) begin
          w_next = S_IDLE;
        end else begin
          w_load = 1'b1;
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        if (i_abort) begin
          w_next = S_IDLE;
        end else begin
          w_we = 1'b1;
          w_en = 1'b1;
          if (w_last) w_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  fb_raster_scan u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_en   (w_en),
    .i_xl   (w_xl),
    .i_xr   (w_xr),
    .i_yt   (w_yt),
    .i_yb   (w_yb),
    .o_x    (w_x),
    .o_y    (w_y),
    .o_last (w_last)
  );

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_fb_we     = w_we;
  assign o_done      = w_done;
  assign o_fb_addr   = {w_y, w_x};
  assign o_fb_data   = r_colour;

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_fill.sv
`default_nettype none
// ============================================================================
// Module  : tb_fb_rect_fill
// Brief   : Scoreboard bench for fb_rect_fill against a rectangle-list model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fb_rect_fill;

  localparam int c_H = 160;
  localparam int c_V = 120;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cmd_valid, i_cmd_colour, i_abort;
  logic [7:0]  i_cmd_x0, i_cmd_x1;
  logic [6:0]  i_cmd_y0, i_cmd_y1;
  logic        o_cmd_ready, o_fb_data, o_fb_we, o_busy, o_done;
  logic [14:0] o_fb_addr;

  typedef struct {
    int cyc;
    bit done;
    int addr;
    int data;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  fb_rect_fill #(.H_PIXELS(c_H), .V_PIXELS(c_V)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_x0     (i_cmd_x0),
    .i_cmd_x1     (i_cmd_x1),
    .i_cmd_y0     (i_cmd_y0),
    .i_cmd_y1     (i_cmd_y1),
    .i_cmd_colour (i_cmd_colour),
    .i_abort      (i_abort),
    .o_fb_addr    (o_fb_addr),
    .o_fb_data    (o_fb_data),
    .o_fb_we      (o_fb_we),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: every pixel of the sorted, clamped rectangle in row-major
  // order, one per cycle starting one cycle after the accept cycle.
  task automatic model_push(input int x0, input int y0, input int x1, input int y1,
                            input int c, input int acc, input int limit,
                            input bit with_done, output int n);
    int xl, xr, yt, yb, k;
    xl = (x0 < x1) ? x0 : x1;  xr = (x0 < x1) ? x1 : x0;
    yt = (y0 < y1) ? y0 : y1;  yb = (y0 < y1) ? y1 : y0;
    if (xl > c_H - 1) xl = c_H - 1;
    if (xr > c_H - 1) xr = c_H - 1;
    if (yt > c_V - 1) yt = c_V - 1;
    if (yb > c_V - 1) yb = c_V - 1;
    k = 0;
    for (int y = yt; y <= yb; y++)
      for (int x = xl; x <= xr; x++) begin
        if (limit < 0 || k < limit) sb.push_back('{acc + 1 + k, 1'b0, y * 256 + x, c});
        k++;
      end
    n = (xr - xl + 1) * (yb - yt + 1);
    if (with_done) sb.push_back('{acc + 1 + n, 1'b1, 0, 0});
  endtask

  // Called #1 after a rising edge; returns the cycle index of the accept edge.
  task automatic do_cmd(input int x0, input int y0, input int x1, input int y1,
                        input int c, input bit abort_idle, output int acc);
    bit rdy;
    i_cmd_x0 = 8'(x0);  i_cmd_x1 = 8'(x1);
    i_cmd_y0 = 7'(y0);  i_cmd_y1 = 7'(y1);
    i_cmd_colour = c[0];
    i_cmd_valid  = 1'b1;
    i_abort      = abort_idle;
    acc = -1;
    for (int t = 0; t < 40000; t++) begin
      rdy = o_cmd_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    i_cmd_valid = 1'b0;
    i_abort     = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 40000; t++) begin
      if (o_cmd_ready && sb.size() == 0) return;
      @(posedge clk); #1;
    end
    chk("idle_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL missed_event: cycle %0d done=%0d addr=%0d expected but not seen",
                 sb[0].cyc, sb[0].done, sb[0].addr);
        void'(sb.pop_front());
      end
      if (o_fb_we) begin
        n_checks++;
        if (sb.size() == 0 || sb[0].done || sb[0].cyc != cyc ||
            sb[0].addr != int'(o_fb_addr) || sb[0].data != int'(o_fb_data)) begin
          n_fail++;
          if (sb.size() == 0)
            $display("FAIL write: got addr %0d data %0d at cycle %0d, expected no write",
                     o_fb_addr, o_fb_data, cyc);
          else
            $display("FAIL write: got addr %0d data %0d cycle %0d, expected done=%0d addr %0d data %0d cycle %0d",
                     o_fb_addr, o_fb_data, cyc, sb[0].done, sb[0].addr, sb[0].data, sb[0].cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) void'(sb.pop_front());
      end
      if (o_done) begin
        n_checks++;
        if (sb.size() == 0 || !sb[0].done || sb[0].cyc != cyc) begin
          n_fail++;
          $display("FAIL done_pulse: got done at cycle %0d, expected next event cycle %0d done=%0d",
                   cyc, (sb.size() > 0) ? sb[0].cyc : -1, (sb.size() > 0) ? sb[0].done : 1'b0);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) void'(sb.pop_front());
      end
    end
  end

  initial begin
    int a1, a2, n;
    rst_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_colour = 1'b0; i_abort = 1'b0;
    i_cmd_x0 = '0; i_cmd_x1 = '0; i_cmd_y0 = '0; i_cmd_y1 = '0;
    #3;
    chk("rst_ready", o_cmd_ready, 1);
    chk("rst_we",    o_fb_we,     0);
    chk("rst_done",  o_done,      0);
    chk("rst_busy",  o_busy,      0);
    chk("rst_addr",  o_fb_addr,   0);
    chk("rst_data",  o_fb_data,   0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Small rectangle, with ABORT held while idle (must be ignored).
    do_cmd(2, 3, 4, 4, 1, 1'b1, a1);
    model_push(2, 3, 4, 4, 1, a1, -1, 1'b1, n);
    chk("small_count", n, 6);
    wait_idle();

    // Reversed corners give the same raster as ordered corners.
    do_cmd(10, 5, 7, 1, 0, 1'b0, a1);
    model_push(10, 5, 7, 1, 0, a1, -1, 1'b1, n);
    wait_idle();
    do_cmd(7, 1, 10, 5, 1, 1'b0, a1);
    model_push(7, 1, 10, 5, 1, a1, -1, 1'b1, n);
    chk("swap_count", n, 20);
    wait_idle();

    // Out-of-range corners clamp to the framebuffer edge.
    do_cmd(155, 118, 200, 127, 1, 1'b0, a1);
    model_push(155, 118, 200, 127, 1, a1, -1, 1'b1, n);
    chk("clamp_count", n, 10);
    wait_idle();

    // Single pixel, then a back-to-back command with valid kept high.
    do_cmd(0, 0, 0, 0, 1, 1'b0, a1);
    model_push(0, 0, 0, 0, 1, a1, -1, 1'b1, n);
    do_cmd(5, 6, 7, 7, 1, 1'b0, a2);
    model_push(5, 6, 7, 7, 1, a2, -1, 1'b1, n);
    chk("b2b_accept_cycle", a2 - a1, 4);
    wait_idle();

    // Full screen, abort in the cycle that would carry write 101.
    do_cmd(0, 0, 159, 119, 1, 1'b0, a1);
    model_push(0, 0, 159, 119, 1, a1, 100, 1'b0, n);
    repeat (101) @(posedge clk);
    #1;
    i_abort = 1'b1;
    #1;
    chk("abort_we_gated", o_fb_we, 0);
    @(posedge clk); #1;
    i_abort = 1'b0;
    chk("abort_ready_next", o_cmd_ready, 1);
    chk("abort_busy_next",  o_busy,      0);
    wait_idle();

    // Reset between edges in the middle of a fill.
    do_cmd(20, 10, 60, 30, 1, 1'b0, a1);
    model_push(20, 10, 60, 30, 1, a1, -1, 1'b1, n);
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_we",   o_fb_we,   0);
    chk("midrst_busy", o_busy,    0);
    chk("midrst_addr", o_fb_addr, 0);
    chk("midrst_done", o_done,    0);
    while (sb.size() > 0 && sb[$].cyc >= cyc) void'(sb.pop_back());
    i_cmd_x0 = 8'd3; i_cmd_x1 = 8'd1; i_cmd_y0 = 7'd2; i_cmd_y1 = 7'd1;
    i_cmd_colour = 1'b0; i_cmd_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    a1 = cyc;
    i_cmd_valid = 1'b0;
    chk("post_rst_accept", o_busy, 1);
    model_push(3, 2, 1, 1, 0, a1, -1, 1'b1, n);
    wait_idle();

    // Randomised rectangles; some pulse ABORT during FINISH (ignored).
    for (int r = 0; r < 25; r++) begin
      int x0, x1, y0, y1, c;
      x0 = $urandom_range(0, 255);
      x1 = (x0 + $urandom_range(0, 15)) & 255;
      y0 = $urandom_range(0, 127);
      y1 = (y0 + $urandom_range(0, 7)) & 127;
      c  = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        do_cmd(x1, y1, x0, y0, c, 1'b0, a1);
        model_push(x1, y1, x0, y0, c, a1, -1, 1'b1, n);
      end else begin
        do_cmd(x0, y0, x1, y1, c, 1'b0, a1);
        model_push(x0, y0, x1, y1, c, a1, -1, 1'b1, n);
      end
      if ($urandom_range(0, 2) == 0) begin
        repeat (n + 1) @(posedge clk);
        #1;
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
      end
      wait_idle();
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    chk("final_idle", o_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
